vdp_cpu_port: RTL and testbench

CPU-side write/read port of the VDP: the bus-facing writer that fills video RAM and programs the VDP register file, which the display pipeline then reads. It decodes byte accesses on a data port and a control port into register writes, address setup, and auto-incrementing VRAM accesses. VRAM accesses are queued and handed to the RAM arbiter through a request/grant handshake, so the display fetch keeps priority.

---
 rtl/vdp_pkg.sv | 41 ++++
 rtl/vdp_port_fifo.sv | 81 ++++++++
 rtl/vdp_cpu_port.sv | 189 ++++++++++++++++++
 tb/tb_vdp_cpu_port.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_pkg.sv
//============================================================================
// Module  : vdp_pkg
// Purpose : Shared command codes, control FSM states, queue entry layout and
//           status bit positions for the VDP CPU port.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

package vdp_pkg;

    localparam logic [1:0] CMD_WADDR = 2'b00;
    localparam logic [1:0] CMD_RADDR = 2'b01;
    localparam logic [1:0] CMD_REG   = 2'b10;

    typedef enum logic [1:0] {
        ST_CMD      = 2'd0,
        ST_ADDR_LO  = 2'd1,
        ST_ADDR_HI  = 2'd2,
        ST_REG_DATA = 2'd3
    } vdp_state_e;

    localparam int VDP_RAM_BITS = 16;

    typedef struct packed {
        logic                    we;
        logic [VDP_RAM_BITS-1:0] addr;
        logic [7:0]              data;
    } vdp_entry_t;

    localparam int STAT_OVERFLOW = 7;
    localparam int STAT_EMPTY    = 6;
    localparam int STAT_FULL     = 5;

    // Flattened entry width {we, addr, data} for an arbitrary address width.
    function automatic int entry_width(input int ram_bits);
        return ram_bits + 9;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vdp_port_fifo.sv
//============================================================================
// Module  : vdp_port_fifo
// Purpose : VRAM access queue. VDP_PORT_FIFO_EN selects a Depth-entry FIFO;
//           otherwise a single holding register is used.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module vdp_port_fifo #(
    parameter int Width = 25,
    parameter int Depth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o,
    output logic             accept_o,
    output logic             full_o,
    output logic             empty_o
);

    if ((Depth < 2) || ((Depth & (Depth - 1)) != 0)) begin : g_depth_check
        $error("vdp_port_fifo: Depth must be a power of two >= 2");
    end

`ifdef VDP_PORT_FIFO_EN
    localparam int PtrBits = $clog2(Depth);
    localparam int CntW    = PtrBits + 1;

    logic [Width-1:0]   mem_q [Depth];
    logic [PtrBits-1:0] wrPtr_q;
    logic [PtrBits-1:0] rdPtr_q;
    logic [CntW-1:0]    count_q;

    assign full_o   = (count_q == CntW'(Depth));
    assign empty_o  = (count_q == '0);
    assign accept_o = push_i & (~full_o | pop_i);
    assign data_o   = mem_q[rdPtr_q];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (accept_o) wrPtr_q <= wrPtr_q + PtrBits'(1);
            if (pop_i)    rdPtr_q <= rdPtr_q + PtrBits'(1);
            if (accept_o && !pop_i)      count_q <= count_q + CntW'(1);
            else if (!accept_o && pop_i) count_q <= count_q - CntW'(1);
        end
    end

    // When full, push+pop writes the slot being vacated, which becomes the tail.
    always_ff @(posedge clk) begin
        if (accept_o) mem_q[wrPtr_q] <= data_i;
    end
`else
    logic             valid_q;
    logic [Width-1:0] data_q;

    assign full_o   = valid_q;
    assign empty_o  = ~valid_q;
    assign accept_o = push_i & (~valid_q | pop_i);
    assign data_o   = data_q;

    always_ff @(posedge clk) begin
        if (!reset)        valid_q <= 1'b0;
        else if (accept_o) valid_q <= 1'b1;
        else if (pop_i)    valid_q <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (accept_o) data_q <= data_i;
    end
`endif

endmodule

`default_nettype wire

// File: rtl/vdp_cpu_port.sv
//============================================================================
// Module  : vdp_cpu_port
// Purpose : CPU data/control port of the VDP: register writes, address setup
//           and queued auto-incrementing VRAM accesses. Queue depth is set by
//           macro VDP_PORT_FIFO_EN (undefined: single holding register).
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module vdp_cpu_port
    import vdp_pkg::*;
#(
    parameter int RamBits   = 16,
    parameter int FifoDepth = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpuSel,
    input  logic               cpuWr,
    input  logic               cpuMode,
    input  logic [7:0]         cpuDataIn,
    output logic [7:0]         cpuDataOut,
    output logic               cpuWait,
    output logic               ramReq,
    output logic               ramWe,
    output logic [RamBits-1:0] ramAddr,
    output logic [7:0]         ramDataOut,
    input  logic               ramGrant,
    input  logic [7:0]         ramDataIn,
    output logic               regWe,
    output logic [2:0]         regIdx,
    output logic [7:0]         regData
);

    localparam int EW = entry_width(RamBits);

    logic w_ctrlWr, w_ctrlRd, w_dataWr, w_dataRd;
    assign w_ctrlWr = cpuSel &  cpuWr &  cpuMode;
    assign w_ctrlRd = cpuSel & ~cpuWr &  cpuMode;
    assign w_dataWr = cpuSel &  cpuWr & ~cpuMode;
    assign w_dataRd = cpuSel & ~cpuWr & ~cpuMode;

    vdp_state_e state_q, state_d;
    logic w_cmdAddr, w_cmdReg, w_latchLo, w_loadAddr, w_regWrite;

    logic               cmdRead_q;
    logic [7:0]         addrLo_q;
    logic [RamBits-1:0] addr_q;
    logic [2:0]         regIdxPend_q;
    logic               regWe_q;
    logic [2:0]         regIdx_q;
    logic [7:0]         regData_q;
    logic [7:0]         readBuf_q;
    logic [7:0]         cpuDataOut_q;
    logic               overflow_q;
    logic               readPending_q;
    logic               rdGrant_q;

    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_CMD;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (w_dataWr || w_dataRd || w_ctrlRd) begin
            state_d = ST_CMD;
        end else if (w_ctrlWr) begin
            case (state_q)
                ST_CMD: begin
                    case (cpuDataIn[7:6])
                        CMD_WADDR, CMD_RADDR: state_d = ST_ADDR_LO;
                        CMD_REG:              state_d = ST_REG_DATA;
                        default:              state_d = ST_CMD;
                    endcase
                end
                ST_ADDR_LO: state_d = ST_ADDR_HI;
                default:    state_d = ST_CMD;
            endcase
        end
    end

    always_comb begin
        w_cmdAddr  = 1'b0;
        w_cmdReg   = 1'b0;
        w_latchLo  = 1'b0;
        w_loadAddr = 1'b0;
        w_regWrite = 1'b0;
        if (w_ctrlWr) begin
            case (state_q)
                ST_CMD: begin
                    w_cmdAddr = (cpuDataIn[7:6] == CMD_WADDR) || (cpuDataIn[7:6] == CMD_RADDR);
                    w_cmdReg  = (cpuDataIn[7:6] == CMD_REG);
                end
                ST_ADDR_LO:  w_latchLo  = 1'b1;
                ST_ADDR_HI:  w_loadAddr = 1'b1;
                ST_REG_DATA: w_regWrite = 1'b1;
                default:     w_cmdAddr  = 1'b0;
            endcase
        end
    end

    logic [15:0]        w_hiLo;
    logic [RamBits-1:0] w_newAddr, w_pushAddr;
    logic               w_pushRd, w_push, w_pop, w_accept, w_full, w_empty;
    logic [EW-1:0]      w_pushEntry, w_head, w_headQ;
    logic [7:0]         w_status;

    assign w_hiLo      = {cpuDataIn, addrLo_q};
    assign w_newAddr   = RamBits'(w_hiLo);
    assign w_pushRd    = w_dataRd | (w_loadAddr & cmdRead_q);
    assign w_push      = w_dataWr | w_pushRd;
    assign w_pushAddr  = w_loadAddr ? w_newAddr : addr_q;
    assign w_pushEntry = {w_dataWr, w_pushAddr, (w_dataWr ? cpuDataIn : 8'h00)};
    assign w_pop       = ramGrant & ~w_empty;

    vdp_port_fifo #(
        .Width (EW),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_i   (w_push),
        .pop_i    (w_pop),
        .data_i   (w_pushEntry),
        .data_o   (w_head),
        .accept_o (w_accept),
        .full_o   (w_full),
        .empty_o  (w_empty)
    );

    always_comb begin
        w_status                = '0;
        w_status[STAT_OVERFLOW] = overflow_q;
        w_status[STAT_EMPTY]    = w_empty;
        w_status[STAT_FULL]     = w_full;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cmdRead_q     <= 1'b0;
            addrLo_q      <= '0;
            addr_q        <= '0;
            regIdxPend_q  <= '0;
            regWe_q       <= 1'b0;
            regIdx_q      <= '0;
            regData_q     <= '0;
            readBuf_q     <= '0;
            cpuDataOut_q  <= '0;
            overflow_q    <= 1'b0;
            readPending_q <= 1'b0;
            rdGrant_q     <= 1'b0;
        end else begin
            if (w_cmdAddr) cmdRead_q    <= cpuDataIn[6];
            if (w_cmdReg)  regIdxPend_q <= cpuDataIn[2:0];
            if (w_latchLo) addrLo_q     <= cpuDataIn;
            // The address advances even when the queue drops the access.
            if (w_loadAddr)                addr_q <= w_newAddr + RamBits'(cmdRead_q);
            else if (w_dataWr || w_dataRd) addr_q <= addr_q + RamBits'(1);
            regWe_q <= w_regWrite;
            if (w_regWrite) begin
                regIdx_q  <= regIdxPend_q;
                regData_q <= cpuDataIn;
            end
            if (w_dataRd)      cpuDataOut_q <= readBuf_q;
            else if (w_ctrlRd) cpuDataOut_q <= w_status;
            rdGrant_q <= w_pop & ~w_head[EW-1];
            if (rdGrant_q) readBuf_q <= ramDataIn;
            if (w_push && !w_accept) overflow_q <= 1'b1;
            else if (w_ctrlRd)       overflow_q <= 1'b0;
            if (w_pushRd && w_accept) readPending_q <= 1'b1;
            else if (rdGrant_q)       readPending_q <= 1'b0;
        end
    end

    assign w_headQ    = w_empty ? '0 : w_head;
    assign ramReq     = ~w_empty;
    assign ramWe      = w_headQ[EW-1];
    assign ramAddr    = w_headQ[EW-2:8];
    assign ramDataOut = w_headQ[7:0];
    assign cpuWait    = w_full | readPending_q;
    assign cpuDataOut = cpuDataOut_q;
    assign regWe      = regWe_q;
    assign regIdx     = regIdx_q;
    assign regData    = regData_q;

endmodule

`default_nettype wire

// File: tb/tb_vdp_cpu_port.sv
//============================================================================
// Module  : tb_vdp_cpu_port
// Purpose : Self-checking bench for vdp_cpu_port against a queue-based model.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module tb_vdp_cpu_port;
    import vdp_pkg::*;

`ifdef VDP_PORT_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpuSel = 1'b0, cpuWr = 1'b0, cpuMode = 1'b0;
    logic [7:0]  cpuDataIn = 8'h00;
    logic [7:0]  cpuDataOut;
    logic        cpuWait, ramReq, ramWe;
    logic [15:0] ramAddr;
    logic [7:0]  ramDataOut;
    logic        ramGrant = 1'b0;
    logic [7:0]  ramDataIn = 8'h00;
    logic        regWe;
    logic [2:0]  regIdx;
    logic [7:0]  regData;

    vdp_cpu_port #(.RamBits(16), .FifoDepth(4)) dut (
        .clk(clk), .reset(reset), .cpuSel(cpuSel), .cpuWr(cpuWr), .cpuMode(cpuMode),
        .cpuDataIn(cpuDataIn), .cpuDataOut(cpuDataOut), .cpuWait(cpuWait),
        .ramReq(ramReq), .ramWe(ramWe), .ramAddr(ramAddr), .ramDataOut(ramDataOut),
        .ramGrant(ramGrant), .ramDataIn(ramDataIn),
        .regWe(regWe), .regIdx(regIdx), .regData(regData)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: CPU-visible state plus an ideal queue and RAM image.
    vdp_entry_t  m_q[$];
    logic [7:0]  ram [65536];
    int          m_phase;
    bit          m_isRead, m_ovf, m_pend, m_regWe, m_rdNow;
    logic [7:0]  m_lo, m_readBuf, m_dout, m_regData;
    logic [2:0]  m_pendIdx, m_regIdx;
    logic [15:0] m_addr, m_rdAddr;
    int          grantMode;
    logic [15:0] obsAddr[$];
    logic [7:0]  obsData[$];

    function automatic void model_reset();
        m_q.delete();
        m_phase = 0; m_isRead = 0; m_ovf = 0; m_pend = 0; m_regWe = 0; m_rdNow = 0;
        m_lo = 0; m_readBuf = 0; m_dout = 0; m_regData = 0; m_pendIdx = 0; m_regIdx = 0;
        m_addr = 0; m_rdAddr = 0;
    endfunction

    function automatic void mpush(input vdp_entry_t e, input int sz, input bit popped);
        if (sz < DEPTH || popped) begin
            m_q.push_back(e);
            if (!e.we) m_pend = 1;
        end else begin
            m_ovf = 1;
        end
    endfunction

    task automatic check_outputs();
        chk("ramReq", 32'(ramReq), 32'(m_q.size() != 0));
        chk("cpuWait", 32'(cpuWait), 32'((m_q.size() >= DEPTH) || m_pend));
        chk("regWe", 32'(regWe), 32'(m_regWe));
        chk("regIdx", 32'(regIdx), 32'(m_regIdx));
        chk("regData", 32'(regData), 32'(m_regData));
        chk("cpuDataOut", 32'(cpuDataOut), 32'(m_dout));
        if (m_q.size() != 0) begin
            chk("ramWe", 32'(ramWe), 32'(m_q[0].we));
            chk("ramAddr", 32'(ramAddr), 32'(m_q[0].addr));
            if (m_q[0].we) chk("ramDataOut", 32'(ramDataOut), 32'(m_q[0].data));
        end
    endtask

    // Called at a negedge: check, drive one cycle of stimulus, advance model.
    task automatic tick(input bit sel, input bit wr, input bit mode, input logic [7:0] d);
        bit          g, rdNext;
        int          sz;
        logic [7:0]  status, oldBuf;
        logic [15:0] rdNextAddr;
        vdp_entry_t  e;
        check_outputs();
        sz = m_q.size();
        g  = (sz != 0) && (grantMode == 1 || (grantMode == 2 && $urandom_range(0, 1) == 1));
        cpuSel = sel; cpuWr = wr; cpuMode = mode; cpuDataIn = d; ramGrant = g;
        ramDataIn = m_rdNow ? ram[m_rdAddr] : 8'($urandom);
        if (g && ramWe) begin
            obsAddr.push_back(ramAddr);
            obsData.push_back(ramDataOut);
        end
        status = {m_ovf, (sz == 0), (sz == DEPTH), 5'b0};
        oldBuf = m_readBuf;
        rdNext = 0; rdNextAddr = 0;
        if (m_rdNow) begin
            m_readBuf = ram[m_rdAddr];
            m_pend = 0;
        end
        if (g) begin
            e = m_q.pop_front();
            if (e.we) ram[e.addr] = e.data;
            else begin rdNext = 1; rdNextAddr = e.addr; end
        end
        m_regWe = 0;
        if (sel) begin
            if (!mode) begin
                m_phase = 0;
                e.we = wr; e.addr = m_addr; e.data = wr ? d : 8'h00;
                if (!wr) m_dout = oldBuf;
                mpush(e, sz, g);
                m_addr = m_addr + 16'd1;
            end else if (!wr) begin
                m_dout = status; m_ovf = 0; m_phase = 0;
            end else begin
                case (m_phase)
                    0: case (d[7:6])
                           2'b00, 2'b01: begin m_isRead = d[6]; m_phase = 1; end
                           2'b10:        begin m_pendIdx = d[2:0]; m_phase = 3; end
                           default:      m_phase = 0;
                       endcase
                    1: begin m_lo = d; m_phase = 2; end
                    2: begin
                        m_addr = {d, m_lo}; m_phase = 0;
                        if (m_isRead) begin
                            e.we = 0; e.addr = m_addr; e.data = 8'h00;
                            mpush(e, sz, g);
                            m_addr = m_addr + 16'd1;
                        end
                    end
                    default: begin m_regWe = 1; m_regIdx = m_pendIdx; m_regData = d; m_phase = 0; end
                endcase
            end
        end
        m_rdNow = rdNext; m_rdAddr = rdNextAddr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ctrl(input logic [7:0] d); tick(1, 1, 1, d); endtask
    task automatic dwr(input logic [7:0] d);  tick(1, 1, 0, d); endtask
    task automatic idle();                    tick(0, 0, 0, 8'h00); endtask

    task automatic drain();
        int saved = grantMode;
        grantMode = 1;
        repeat (DEPTH + 3) idle();
        grantMode = saved;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) begin
            cpuSel = 1'($urandom); cpuWr = 1'($urandom); cpuMode = 1'($urandom);
            cpuDataIn = 8'($urandom); ramGrant = 1'($urandom); ramDataIn = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1; cpuSel = 1'b0; ramGrant = 1'b0;
        model_reset();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
        model_reset();
        grantMode = 0;
        @(negedge clk);

        do_reset(2);
        chk("rst_cpuDataOut", 32'(cpuDataOut), 0);
        chk("rst_cpuWait", 32'(cpuWait), 0);
        chk("rst_ramReq", 32'(ramReq), 0);
        chk("rst_ramWe", 32'(ramWe), 0);
        chk("rst_ramAddr", 32'(ramAddr), 0);
        chk("rst_ramDataOut", 32'(ramDataOut), 0);
        chk("rst_regWe", 32'(regWe), 0);
        chk("rst_regIdx", 32'(regIdx), 0);
        chk("rst_regData", 32'(regData), 0);
        tick(1, 0, 1, 8'h00);
        chk("rst_status", 32'(cpuDataOut), 32'h40);

        ctrl(8'h83); ctrl(8'h25);
        chk("reg_we", 32'(regWe), 1);
        chk("reg_idx", 32'(regIdx), 3);
        chk("reg_data", 32'(regData), 32'h25);
        idle();
        chk("reg_we_pulse", 32'(regWe), 0);
        chk("reg_idx_hold", 32'(regIdx), 3);

        grantMode = 1;
        obsAddr.delete(); obsData.delete();
        ctrl(8'h00); ctrl(8'h34); ctrl(8'h12);
        dwr(8'hAA); dwr(8'hBB);
        drain();
        chk("burst_count", 32'(obsAddr.size()), 2);
        if (obsAddr.size() == 2) begin
            chk("burst_a0", 32'(obsAddr[0]), 32'h1234);
            chk("burst_d0", 32'(obsData[0]), 32'hAA);
            chk("burst_a1", 32'(obsAddr[1]), 32'h1235);
            chk("burst_d1", 32'(obsData[1]), 32'hBB);
        end

        grantMode = 0;
        ram[16'h2000] = 8'h5C;
        ctrl(8'h40); ctrl(8'h00); ctrl(8'h20);
        chk("rd_head_addr", 32'(ramAddr), 32'h2000);
        chk("rd_wait", 32'(cpuWait), 1);
        grantMode = 1; idle(); grantMode = 0; idle();
        chk("rd_wait_drop", 32'(cpuWait), 0);
        tick(1, 0, 0, 8'h00);
        chk("rd_data", 32'(cpuDataOut), 32'h5C);
        chk("rd_next_addr", 32'(ramAddr), 32'h2001);
        drain();

        obsAddr.delete(); obsData.delete();
        ctrl(8'h00); ctrl(8'h00); ctrl(8'h30);
        for (int i = 0; i < 5; i++) begin
            dwr(8'h60 + 8'(i));
            if (i == DEPTH - 2) chk("ovf_wait_low", 32'(cpuWait), 0);
            if (i == DEPTH - 1) chk("ovf_wait_high", 32'(cpuWait), 1);
        end
        tick(1, 0, 1, 8'h00);
        chk("ovf_stat_set", 32'(cpuDataOut[7]), 1);
        tick(1, 0, 1, 8'h00);
        chk("ovf_stat_clr", 32'(cpuDataOut[7]), 0);
        drain();
        chk("ovf_kept", 32'(obsAddr.size()), 32'(DEPTH));

        grantMode = 1;
        obsAddr.delete(); obsData.delete();
        ctrl(8'h00); ctrl(8'hFF); ctrl(8'hFF);
        dwr(8'h01); dwr(8'h02);
        drain();
        chk("wrap_count", 32'(obsAddr.size()), 2);
        if (obsAddr.size() == 2) begin
            chk("wrap_a0", 32'(obsAddr[0]), 32'hFFFF);
            chk("wrap_a1", 32'(obsAddr[1]), 32'h0000);
        end
        obsAddr.delete(); obsData.delete();
        ctrl(8'h00); dwr(8'h11); ctrl(8'h83); ctrl(8'h07);
        chk("abort_reg_we", 32'(regWe), 1);
        chk("abort_reg_idx", 32'(regIdx), 3);
        chk("abort_reg_data", 32'(regData), 32'h07);
        drain();
        chk("abort_count", 32'(obsAddr.size()), 1);
        if (obsAddr.size() == 1) begin
            chk("abort_addr", 32'(obsAddr[0]), 32'h0001);
            chk("abort_data", 32'(obsData[0]), 32'h11);
        end

        grantMode = 0;
        ctrl(8'h00); ctrl(8'h00); ctrl(8'h05);
        dwr(8'h33); dwr(8'h44);
        do_reset(1);
        chk("midrst_ramReq", 32'(ramReq), 0);
        chk("midrst_cpuWait", 32'(cpuWait), 0);

        grantMode = 2;
        for (int c = 0; c < 4000; c++) begin
            int r = $urandom_range(0, 9);
            if (r < 4)       tick(0, 1'($urandom), 1'($urandom), 8'($urandom));
            else if (r < 6)  ctrl(8'($urandom));
            else if (r == 6) tick(1, 0, 1, 8'($urandom));
            else if (cpuWait && $urandom_range(0, 3) != 0) idle();
            else             tick(1, 1'($urandom), 0, 8'($urandom));
        end
        drain();
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
